// File: rtl/svt_phase_sequencer.sv
// Phase controller: IDLE -> BUILD -> CONNECT -> RUN <-> DRAIN -> DONE, gated by a saturating objection counter.
// Define SVT_PHASE_TIMEOUT_EN to build the RUN/DRAIN watchdog; otherwise timeout is tied to 0.
module svt_phase_sequencer #(
    parameter int N_REQ          = 4,
    parameter int CNT_W          = 8,
    parameter int DRAIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [N_REQ-1:0] ack,
    input  logic [N_REQ-1:0] raise,
    input  logic [N_REQ-1:0] drop,
    output logic [2:0]       phase,
    output logic             phase_start,
    output logic [CNT_W-1:0] obj_count,
    output logic             done,
    output logic             timeout,
    output logic             err_underflow,
    output logic             err_overflow
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUILD   = 3'd1,
        CONNECT = 3'd2,
        RUN     = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } phase_t;

    localparam int SUM_W = CNT_W + 5;
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [N_REQ-1:0] ALL_ACK = '1;
    localparam logic signed [SUM_W-1:0] MAX_S = {5'b0, {CNT_W{1'b1}}};
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES);

    phase_t                  state;
    logic [N_REQ-1:0]        ack_latch;
    logic [DRN_W-1:0]        drain_cnt;
    logic                    counting;
    logic                    cnt_under;
    logic                    cnt_over;
    logic                    acks_complete;
    logic                    wd_expired;
    logic [CNT_W-1:0]        cnt_next;
    logic signed [SUM_W-1:0] delta;
    logic signed [SUM_W-1:0] sum;

    function automatic logic signed [SUM_W-1:0] popcount(input logic [N_REQ-1:0] v);
        logic signed [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_REQ; i++)
            n = n + {{(SUM_W-1){1'b0}}, v[i]};
        return n;
    endfunction

    // Clamp the signed next count into [0, 2^CNT_W-1].
    function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1])
            return '0;
        if (s > MAX_S)
            return '1;
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        counting      = (state == BUILD) || (state == CONNECT) || (state == RUN) || (state == DRAIN);
        delta         = popcount(raise) - popcount(drop);
        sum           = $signed({5'b0, obj_count}) + delta;
        cnt_under     = counting && sum[SUM_W-1];
        cnt_over      = counting && !sum[SUM_W-1] && (sum > MAX_S);
        cnt_next      = counting ? sat_count(sum) : obj_count;
        acks_complete = ((ack_latch | ack) == ALL_ACK);
    end

`ifdef SVT_PHASE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Runs across RUN<->DRAIN bounces; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (state == RUN || state == DRAIN)
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = ((state == RUN) || (state == DRAIN)) && (wd_cnt == WD_LAST);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wd_expired         = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ack_latch     <= '0;
            drain_cnt     <= '0;
            obj_count     <= '0;
            phase_start   <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            obj_count   <= cnt_next;
            if (cnt_under)
                err_underflow <= 1'b1;
            if (cnt_over)
                err_overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= BUILD;
                        phase_start <= 1'b1;
                    end
                end
                BUILD, CONNECT: begin
                    if (acks_complete) begin
                        state       <= (state == BUILD) ? CONNECT : RUN;
                        phase_start <= 1'b1;
                        ack_latch   <= '0;
                    end else begin
                        ack_latch <= ack_latch | ack;
                    end
                end
                RUN, DRAIN: begin
                    // Watchdog expiry wins over a drain completion in the same cycle.
                    if (wd_expired) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (state == RUN) begin
                        if (cnt_next == '0) begin
                            state     <= DRAIN;
                            drain_cnt <= DRN_W'(1);
                        end
                    end else if (cnt_next != '0) begin
                        state     <= RUN;
                        drain_cnt <= '0;
                    end else if (drain_cnt == DRN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_svt_phase_sequencer.sv
// Bench for svt_phase_sequencer: spec-level reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_svt_phase_sequencer;
    localparam int N_REQ          = 4;
    localparam int CNT_W          = 8;
    localparam int DRAIN_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int MAXC           = (1 << CNT_W) - 1;
`ifdef SVT_PHASE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [N_REQ-1:0] ack   = '0;
    logic [N_REQ-1:0] raise = '0;
    logic [N_REQ-1:0] drop  = '0;
    logic [2:0]       phase;
    logic             phase_start;
    logic [CNT_W-1:0] obj_count;
    logic             done;
    logic             timeout;
    logic             err_underflow;
    logic             err_overflow;

    int nvec = 0;
    int nerr = 0;
    int seq1 [6] = '{1, 2, 3, 4, 4, 5};

    always #5 clock = ~clock;

    svt_phase_sequencer #(
        .N_REQ(N_REQ), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .ack(ack), .raise(raise), .drop(drop),
        .phase(phase), .phase_start(phase_start), .obj_count(obj_count), .done(done),
        .timeout(timeout), .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    // Reference model: phase number, ack set seen, count as a plain integer,
    // consecutive zero-count cycles, and cycles spent in RUN/DRAIN.
    typedef struct packed {
        int         ph;
        logic [3:0] seen;
        int         cnt;
        int         zeros;
        int         wd;
        bit         ps;
        bit         to;
        bit         uf;
        bit         of;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s, input logic st,
                                           input logic [3:0] a, input logic [3:0] r, input logic [3:0] d);
        mstate_t n;
        int sum;
        n   = s;
        sum = s.cnt;
        if (s.ph >= 1 && s.ph <= 4) begin
            sum = s.cnt + $countones(r) - $countones(d);
            if (sum < 0) begin
                sum  = 0;
                n.uf = 1'b1;
            end
            if (sum > MAXC) begin
                sum  = MAXC;
                n.of = 1'b1;
            end
        end
        n.cnt = sum;
        case (s.ph)
            0: if (st) n.ph = 1;
            1, 2: begin
                if ((s.seen | a) == 4'hF) begin
                    n.ph   = s.ph + 1;
                    n.seen = '0;
                end else begin
                    n.seen = s.seen | a;
                end
            end
            3, 4: begin
                n.wd    = s.wd + 1;
                n.zeros = (sum == 0) ? s.zeros + 1 : 0;
                if (TO_EN && n.wd >= TIMEOUT_CYCLES) begin
                    n.ph = 5;
                    n.to = 1'b1;
                end else if (n.zeros > DRAIN_CYCLES) begin
                    n.ph = 5;
                end else begin
                    n.ph = (n.zeros == 0) ? 3 : 4;
                end
            end
            default: ;
        endcase
        n.ps = (n.ph > s.ph) && (n.ph <= 3);
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset)
            m <= '0;
        else
            m <= model_next(m, start, ack, raise, drop);
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("m_phase", int'(phase), m.ph);
        check("m_phase_start", int'(phase_start), int'(m.ps));
        check("m_obj_count", int'(obj_count), m.cnt);
        check("m_done", int'(done), int'(m.ph == 5));
        check("m_timeout", int'(timeout), int'(m.to));
        check("m_err_underflow", int'(err_underflow), int'(m.uf));
        check("m_err_overflow", int'(err_overflow), int'(m.of));
    end

    // Apply one input vector for one clock; returns with outputs settled after that edge.
    task automatic step(input logic s, input logic [3:0] a, input logic [3:0] r, input logic [3:0] d);
        @(negedge clock);
        #1;
        start = s;
        ack   = a;
        raise = r;
        drop  = d;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        start = 1'b0;
        ack   = '0;
        raise = '0;
        drop  = '0;
        @(posedge clock);
        @(posedge clock);
        #2;
        check("rst_phase", int'(phase), 0);
        check("rst_obj", int'(obj_count), 0);
        check("rst_done", int'(done), 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();

        // Straight-through run with all acks held and no objections.
        step(1'b1, 4'hF, 4'h0, 4'h0);
        check("t1_phase_0", int'(phase), seq1[0]);
        check("t1_pstart_0", int'(phase_start), 1);
        for (int i = 1; i < 6; i++) begin
            step(1'b0, 4'hF, 4'h0, 4'h0);
            check("t1_phase", int'(phase), seq1[i]);
        end
        check("t1_done", int'(done), 1);
        check("t1_timeout", int'(timeout), 0);

        // Staggered acks, then raise/drop pattern in RUN.
        do_reset();
        step(1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 4'b0001, 4'h0, 4'h0);
        check("t2_build_a", int'(phase), 1);
        step(1'b0, 4'b0100, 4'h0, 4'h0);
        check("t2_build_b", int'(phase), 1);
        step(1'b0, 4'b0010, 4'h0, 4'h0);
        check("t2_build_c", int'(phase), 1);
        step(1'b0, 4'b1000, 4'h0, 4'h0);
        check("t2_connect", int'(phase), 2);
        step(1'b0, 4'hF, 4'b0011, 4'h0);
        check("t2_run", int'(phase), 3);
        check("t2_obj2", int'(obj_count), 2);
        step(1'b0, 4'h0, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'h0, 4'b0001);
        check("t2_obj1", int'(obj_count), 1);
        step(1'b0, 4'h0, 4'h0, 4'b0010);
        check("t2_obj0", int'(obj_count), 0);
        check("t2_drain", int'(phase), 4);
        step(1'b0, 4'h0, 4'h0, 4'h0);
        check("t2_drain2", int'(phase), 4);
        step(1'b0, 4'h0, 4'h0, 4'h0);
        check("t2_done", int'(phase), 5);
        check("t2_uf", int'(err_underflow), 0);

        // Underflow, raise+drop netting, DRAIN bounce, ignored inputs in DONE.
        do_reset();
        step(1'b1, 4'hF, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'b0001, 4'h0);
        check("t3_obj1", int'(obj_count), 1);
        step(1'b0, 4'h0, 4'b0100, 4'b0100);
        check("t3_net0", int'(obj_count), 1);
        step(1'b0, 4'h0, 4'h0, 4'b0011);
        check("t3_uf_obj", int'(obj_count), 0);
        check("t3_uf", int'(err_underflow), 1);
        check("t3_drain", int'(phase), 4);
        step(1'b0, 4'h0, 4'b0010, 4'h0);
        check("t3_bounce", int'(phase), 3);
        check("t3_bounce_obj", int'(obj_count), 1);
        step(1'b0, 4'h0, 4'h0, 4'b0010);
        step(1'b0, 4'h0, 4'h0, 4'h0);
        check("t3_no_early", int'(done), 0);
        step(1'b0, 4'h0, 4'h0, 4'h0);
        check("t3_done", int'(phase), 5);
        step(1'b1, 4'hF, 4'hF, 4'h0);
        check("t3_frozen", int'(obj_count), 0);

        // Overflow saturation while held in BUILD.
        do_reset();
        step(1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 64; i++)
            step(1'b0, 4'h0, 4'hF, 4'h0);
        check("t4_sat", int'(obj_count), 255);
        check("t4_of", int'(err_overflow), 1);
        check("t4_build", int'(phase), 1);
        step(1'b0, 4'hF, 4'h0, 4'hF);
        step(1'b0, 4'hF, 4'h0, 4'h0);
        for (int i = 0; i < 70; i++)
            step(1'b0, 4'h0, 4'h0, 4'hF);
        check("t4_done", int'(done), 1);

        // Stuck objection: watchdog if built, otherwise RUN forever.
        do_reset();
        step(1'b1, 4'hF, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'b0001, 4'h0);
        check("t5_run", int'(phase), 3);
        n = 0;
        while (!done && n < 40) begin
            step(1'b0, 4'h0, 4'h0, 4'h0);
            n++;
        end
`ifdef SVT_PHASE_TIMEOUT_EN
        check("t5_to_cycles", n, 16);
        check("t5_timeout", int'(timeout), 1);
        check("t5_obj", int'(obj_count), 1);
`else
        check("t5_hang_phase", int'(phase), 3);
        check("t5_hang_done", int'(done), 0);
        check("t5_no_timeout", int'(timeout), 0);
`endif

        // Asynchronous reset in the middle of RUN.
        do_reset();
        step(1'b1, 4'h0, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'h0, 4'b0001);
        check("t6_uf_pre", int'(err_underflow), 1);
        step(1'b0, 4'hF, 4'b0011, 4'h0);
        step(1'b0, 4'hF, 4'h0, 4'h0);
        check("t6_run", int'(phase), 3);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_phase", int'(phase), 0);
        check("t6_async_obj", int'(obj_count), 0);
        check("t6_async_uf", int'(err_underflow), 0);
        check("t6_async_done", int'(done), 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        step(1'b0, 4'h0, 4'h0, 4'h0);
        check("t6_idle", int'(phase), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
